// File: rtl/ahb_prio_arbiter.sv
// AHB priority arbiter: registered one-hot hgrant, hmaster lags hgrant by one hready-high edge; hready=0 freezes all state.
// Fixed bursts and locked transfers are atomic. Define AHB_ARB_RR_TIE_EN for round-robin tie-break (default: lowest index).
module ahb_prio_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int PRIO_W         = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MIDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic [NUM_MASTERS-1:0]        hbusreq,
  input  logic [NUM_MASTERS-1:0]        hlock,
  input  logic [NUM_MASTERS*PRIO_W-1:0] prio,
  input  logic [1:0]                    htrans,
  input  logic [2:0]                    hburst,
  input  logic                          hready,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic [MIDX_W-1:0]             hmaster,
  output logic                          hmastlock
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [NUM_MASTERS-1:0] GNT_ONE = NUM_MASTERS'(1);
  localparam logic [NUM_MASTERS-1:0] GNT_RST = GNT_ONE << DEFAULT_MASTER;

  typedef enum logic [1:0] {ST_PARK, ST_OWNED, ST_BURST, ST_LOCKED} state_e;

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   hgrant_q;
  logic [MIDX_W-1:0]        hmaster_q;
  logic                     hmastlock_q;
  logic [3:0]               beats_left_q;
  logic [3:0]               nbl;
  logic                     own_lock;
  logic                     any_req;
  logic                     arb_ok;
  logic                     lock_hold;
  logic [PRIO_W-1:0]        max_p;
  logic [MIDX_W-1:0]        win;
  logic [NUM_MASTERS-1:0]   win_oh;
  logic [MIDX_W-1:0]        gnt_idx;

  assign own_lock = hlock[hmaster_q];
  assign any_req  = |hbusreq;

  // Value beats_left takes at this edge; held when hready is low.
  always_comb begin
    nbl = beats_left_q;
    if (hready) begin
      case (htrans)
        TRANS_NONSEQ: begin
          case (hburst)
            3'd2, 3'd3: nbl = 4'd3;
            3'd4, 3'd5: nbl = 4'd7;
            3'd6, 3'd7: nbl = 4'd15;
            default:    nbl = 4'd0;
          endcase
        end
        TRANS_SEQ: nbl = (beats_left_q == 4'd0) ? 4'd0 : beats_left_q - 4'd1;
        default:   nbl = beats_left_q;
      endcase
    end
  end

  // A lock held by the current owner always beats a pending re-arbitration.
  assign arb_ok = hready && !own_lock && (nbl <= 4'd1);

  always_comb begin
    max_p = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hbusreq[i] && (prio[i*PRIO_W +: PRIO_W] > max_p)) begin
        max_p = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

`ifdef AHB_ARB_RR_TIE_EN
  logic [MIDX_W-1:0] rr_ptr_q;
  logic              found;
  int                cand;

  always_comb begin
    win   = MIDX_W'(DEFAULT_MASTER);
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && hbusreq[cand] && (prio[cand*PRIO_W +: PRIO_W] == max_p)) begin
        found = 1'b1;
        win   = MIDX_W'(cand);
      end
    end
  end
`else
  always_comb begin
    win = MIDX_W'(DEFAULT_MASTER);
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      if (hbusreq[i] && (prio[i*PRIO_W +: PRIO_W] == max_p)) win = MIDX_W'(i);
    end
  end
`endif

  assign win_oh = GNT_ONE << win;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) gnt_idx = MIDX_W'(i);
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      hgrant_q     <= GNT_RST;
      hmaster_q    <= MIDX_W'(DEFAULT_MASTER);
      hmastlock_q  <= 1'b0;
      beats_left_q <= 4'd0;
    end else if (hready) begin
      beats_left_q <= nbl;
      hmaster_q    <= gnt_idx;
      hmastlock_q  <= hlock[gnt_idx];
      if (arb_ok) hgrant_q <= win_oh;
    end
  end

`ifdef AHB_ARB_RR_TIE_EN
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      rr_ptr_q <= MIDX_W'(DEFAULT_MASTER);
    end else if (arb_ok && (win_oh != hgrant_q)) begin
      rr_ptr_q <= win;
    end
  end
`endif

  always_ff @(posedge hclk) begin
    if (!hreset_n) state_q <= ST_PARK;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hready) begin
      case (state_q)
        ST_PARK:  if (any_req) state_d = ST_OWNED;
        ST_OWNED: begin
          if (nbl > 4'd1)    state_d = ST_BURST;
          else if (own_lock) state_d = ST_LOCKED;
          else if (!any_req) state_d = ST_PARK;
        end
        ST_BURST: if (nbl <= 4'd1) state_d = ST_OWNED;
        ST_LOCKED: begin
          if (!own_lock && ((htrans == TRANS_IDLE) || (htrans == TRANS_NONSEQ))) state_d = ST_OWNED;
        end
        default: state_d = ST_PARK;
      endcase
    end
  end

  always_comb begin
    lock_hold = (state_q == ST_LOCKED) && own_lock;
  end

  a_lock_hold: assert property (@(posedge hclk) disable iff (!hreset_n) lock_hold |=> $stable(hgrant_q));

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_prio_arbiter.sv
// Bench for ahb_prio_arbiter (4 masters, 2-bit priority, default master 0): directed scenarios plus random traffic.
module tb_ahb_prio_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NSEQ = 2'd2;
  localparam logic [1:0] SEQ  = 2'd3;

  logic       clk = 1'b0;
  logic       hreset_n = 1'b0;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [7:0] prio = '0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hburst = '0;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  always #5 clk = ~clk;

  ahb_prio_arbiter #(.NUM_MASTERS(N), .PRIO_W(2), .DEFAULT_MASTER(DEF)) dut (
    .hclk(clk), .hreset_n(hreset_n), .hbusreq(hbusreq), .hlock(hlock), .prio(prio),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] mst;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pr[4];
  int   blen[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
  int   m_gnt, m_mst, m_left, m_rr;
  bit   m_lk;
  logic [3:0] lkv = '0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Highest priority wins; within a level the score prefers the smallest tie distance.
  function automatic int pick(logic [3:0] req);
    int best = DEF;
    int bs = -1;
    int sc, d;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
`ifdef AHB_ARB_RR_TIE_EN
        d = (i - m_rr - 1 + 2*N) % N;
`else
        d = i;
`endif
        sc = pr[i]*N + (N - 1 - d);
        if (sc > bs) begin
          bs = sc;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_step(input logic rn, input logic [3:0] rq, input logic [3:0] lk,
                            input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    int nl, g;
    if (!rn) begin
      m_gnt = DEF; m_mst = DEF; m_lk = 1'b0; m_left = 0; m_rr = DEF;
    end else if (rdy) begin
      nl = m_left;
      if (tr == NSEQ) nl = blen[bu] - 1;
      else if (tr == SEQ && nl > 0) nl = nl - 1;
      g = m_gnt;
      if (!lk[m_mst] && nl <= 1) g = pick(rq);
      m_mst = m_gnt;
      m_lk  = lk[m_gnt];
      if (g != m_gnt) m_rr = g;
      m_gnt  = g;
      m_left = nl;
    end
    exp_q.push_back('{gnt: 4'(1 << m_gnt), mst: 2'(m_mst), lk: m_lk});
  endtask

  task automatic cyc(input logic rn, input logic [3:0] rq, input logic [3:0] lk,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    @(negedge clk);
    hreset_n = rn; hbusreq = rq; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
    prio = {2'(pr[3]), 2'(pr[2]), 2'(pr[1]), 2'(pr[0])};
    model_step(rn, rq, lk, tr, bu, rdy);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_hgrant", hgrant, e.gnt);
      chk("sb_hmaster", hmaster, e.mst);
      chk("sb_hmastlock", hmastlock, e.lk);
    end
  end

  initial begin
    int e6;
    pr = '{0, 0, 0, 0};
    // Reset, then idle with no requests: parked on master 0
    repeat (2) cyc(0, 4'b0000, 4'b0000, IDLE, 3'd0, 1);
    repeat (5) cyc(1, 4'b0000, 4'b0000, IDLE, 3'd0, 1);
    settle; chk("t1_hgrant", hgrant, 4'b0001); chk("t1_hmaster", hmaster, 0); chk("t1_hmastlock", hmastlock, 0);

    // Two requesters, m2 has higher priority
    pr = '{0, 1, 3, 0};
    cyc(1, 4'b0110, 4'b0000, IDLE, 3'd0, 1);
    settle; chk("t2_hgrant", hgrant, 4'b0100);
    cyc(1, 4'b0110, 4'b0000, IDLE, 3'd0, 1);
    settle; chk("t2_hmaster", hmaster, 2);

    // m1 runs INCR4, m3 arrives at priority 3 and waits for the last beat
    pr = '{0, 2, 0, 0};
    repeat (2) cyc(1, 4'b0010, 4'b0000, IDLE, 3'd0, 1);
    pr = '{0, 2, 0, 3};
    cyc(1, 4'b1010, 4'b0000, NSEQ, 3'd3, 1);
    cyc(1, 4'b1010, 4'b0000, SEQ, 3'd3, 1);
    settle; chk("t3_hold_beat2", hgrant, 4'b0010);
    cyc(1, 4'b1010, 4'b0000, SEQ, 3'd3, 1);
    settle; chk("t3_move_beat3", hgrant, 4'b1000);
    cyc(1, 4'b1010, 4'b0000, SEQ, 3'd3, 1);
    settle; chk("t3_hmaster", hmaster, 3);

    // m2 locked over three SINGLEs while m3 requests at priority 3
    pr = '{0, 0, 2, 0};
    repeat (2) cyc(1, 4'b0100, 4'b0100, IDLE, 3'd0, 1);
    pr = '{0, 0, 2, 3};
    repeat (3) cyc(1, 4'b1100, 4'b0100, NSEQ, 3'd0, 1);
    settle; chk("t4_hgrant", hgrant, 4'b0100); chk("t4_hmastlock", hmastlock, 1);
    cyc(1, 4'b1100, 4'b0000, IDLE, 3'd0, 1);
    settle; chk("t4_release", hgrant, 4'b1000);

    // hready low freezes a pending grant change
    pr = '{3, 0, 0, 0};
    repeat (4) cyc(1, 4'b0001, 4'b0000, IDLE, 3'd0, 0);
    settle; chk("t5_frozen_gnt", hgrant, 4'b1000); chk("t5_frozen_mst", hmaster, 2);
    cyc(1, 4'b0001, 4'b0000, IDLE, 3'd0, 1);
    settle; chk("t5_resume_gnt", hgrant, 4'b0001); chk("t5_resume_mst", hmaster, 3);

    // All four request at equal priority
    cyc(0, 4'b0000, 4'b0000, IDLE, 3'd0, 1);
    pr = '{2, 2, 2, 2};
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 4'b1111, 4'b0000, NSEQ, 3'd0, 1);
`ifdef AHB_ARB_RR_TIE_EN
      e6 = k % 4;
`else
      e6 = 0;
`endif
      settle; chk("t6_tie", hgrant, 4'(1 << e6));
    end

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if (c % 16 == 0) begin
        for (int i = 0; i < 4; i++) pr[i] = $urandom_range(0, 3);
      end
      for (int i = 0; i < 4; i++) begin
        if (lkv[i]) begin
          if ($urandom_range(0, 3) == 0) lkv[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          lkv[i] = 1'b1;
        end
      end
      cyc(($urandom_range(0, 99) != 0), 4'($urandom), lkv, 2'($urandom), 3'($urandom),
          ($urandom_range(0, 3) != 0));
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
